// File: rtl/serializer_pkg.sv
// Shared types and constants for the byte serializer.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
package serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam int BYTE_W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif
  // Wide enough to count to FRAME_LEN in either build
  localparam int CNT_W = 4;
endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrapping pointers; pushes while full are dropped even when a pop
// happens in the same cycle. Head byte is visible combinationally on dout.
module byte_fifo
  import serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so plain increment wraps the pointers
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial byte transmitter: FIFO feeds an MSB-first shifter, one idle cycle
// between frames. SERIALIZER_PARITY_EN adds a trailing even-parity bit.
module byte_serializer
  import serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock1M,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              enqueue_in,
  output logic              data_out,
  output logic              write_out,
  output logic              status_out,
  output logic              busy_out
);
  ser_state_t        state, state_nxt;
  logic [BYTE_W-1:0] shift_q, shift_nxt, fifo_dout;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              dout_nxt, wr_nxt, pop, fifo_full, fifo_empty;
`ifdef SERIALIZER_PARITY_EN
  logic              par_q, par_nxt;
`endif

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .gclk   (clock1M),
    .grst_n (reset),
    .push   (enqueue_in),
    .pop    (pop),
    .din    (data_in),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign status_out = fifo_full;
  assign busy_out   = ~fifo_empty | (state == SHIFT);

  // The pop edge already presents bit7, so the shifter is loaded pre-shifted
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    dout_nxt    = 1'b0;
    wr_nxt      = 1'b0;
    pop         = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_nxt     = par_q;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          dout_nxt    = fifo_dout[BYTE_W-1];
          wr_nxt      = 1'b1;
          shift_nxt   = {fifo_dout[BYTE_W-2:0], 1'b0};
          bit_cnt_nxt = CNT_W'(1);
          state_nxt   = SHIFT;
`ifdef SERIALIZER_PARITY_EN
          par_nxt     = ^fifo_dout;
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt == CNT_W'(FRAME_LEN)) begin
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          wr_nxt      = 1'b1;
          bit_cnt_nxt = bit_cnt + 1'b1;
`ifdef SERIALIZER_PARITY_EN
          if (bit_cnt == CNT_W'(BYTE_W)) begin
            dout_nxt = par_q;
          end else begin
            dout_nxt  = shift_q[BYTE_W-1];
            shift_nxt = {shift_q[BYTE_W-2:0], 1'b0};
          end
`else
          dout_nxt  = shift_q[BYTE_W-1];
          shift_nxt = {shift_q[BYTE_W-2:0], 1'b0};
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      data_out  <= 1'b0;
      write_out <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_q   <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      data_out  <= dout_nxt;
      write_out <= wr_nxt;
`ifdef SERIALIZER_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench for byte_serializer: expected frames queued at enqueue time,
// compared as the serial monitor reassembles them.
`timescale 1ns/1ps
module tb_byte_serializer;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clock1M = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       enqueue_in = 1'b0;
  logic       data_out, write_out, status_out, busy_out;

  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, nbits = 0, hi_cycles = 0, nframes = 0;
  logic [8:0] cur = '0;
  logic [8:0] sb[$];
  int         starts[$];

  byte_serializer #(.DEPTH(4)) dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .data_in    (data_in),
    .enqueue_in (enqueue_in),
    .data_out   (data_out),
    .write_out  (write_out),
    .status_out (status_out),
    .busy_out   (busy_out)
  );

  always #500 clock1M = ~clock1M;
  always @(posedge clock1M) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] frame_of(input logic [7:0] b);
    return (FRAME == 9) ? {b, ^b} : {1'b0, b};
  endfunction

  // Serial monitor: reassembles frames, checks length, data and idle-low data_out
  always @(negedge clock1M) begin
    if (!reset) begin
      nbits = 0;
      cur   = '0;
    end else if (write_out) begin
      if (nbits == 0) begin
        cur = '0;
        starts.push_back(cyc);
      end
      cur = {cur[7:0], data_out};
      nbits++;
      hi_cycles++;
    end else begin
      chk("idle_data_low", data_out, 1'b0);
      if (nbits != 0) begin
        chk("frame_len", nbits, FRAME);
        chk("frame_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) chk("frame_data", cur, sb.pop_front());
        nframes++;
        nbits = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clock1M);
    #1;
  endtask

  task automatic enq(input logic [7:0] b, input bit expect_it);
    data_in    = b;
    enqueue_in = 1'b1;
    if (expect_it) sb.push_back(frame_of(b));
    tick();
    enqueue_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((busy_out || write_out || nbits != 0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, n < budget, 1'b1);
    chk({tag, "_busy_end"}, busy_out, 1'b0);
  endtask

  logic [7:0] burst[4] = '{8'hCC, 8'hF0, 8'h0F, 8'h33};
  logic [7:0] ovf[6]   = '{8'h55, 8'h99, 8'hFF, 8'h00, 8'h11, 8'h22};

  initial begin
    int e, hs;
    #1;
    chk("rst_write", write_out, 1'b0);
    chk("rst_data", data_out, 1'b0);
    chk("rst_status", status_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();

    // single byte: first bit one cycle after the enqueue edge
    starts.delete();
    e = cyc + 1;
    enq(8'hAA, 1'b1);
    wait_drain("single", 40);
    chk("single_nframes", starts.size(), 1);
    if (starts.size() > 0) chk("single_latency", starts[0], e + 1);

    // burst of four: a pop precedes the 4th enqueue so the FIFO never fills
    starts.delete();
    for (int i = 0; i < 4; i++) begin
      enq(burst[i], 1'b1);
      chk("burst_status", status_out, 1'b0);
    end
    wait_drain("burst", 100);
    chk("burst_nframes", starts.size(), 4);
    if (starts.size() == 4)
      for (int i = 0; i < 3; i++) chk("burst_gap", starts[i+1] - starts[i], FRAME + 1);

    // overflow: the sixth byte arrives while full and must never be sent
    for (int i = 0; i < 6; i++) begin
      enq(ovf[i], i < 5);
      chk("ovf_status", status_out, (i >= 4) ? 1'b1 : 1'b0);
    end
    wait_drain("ovf", 200);
    tick(); tick();
    chk("ovf_no_extra", nbits + int'(write_out), 0);

    // reset three bits into a frame
    enq(8'hF0, 1'b1);
    tick(); tick(); tick();
    chk("rst_mid_bits", nbits, 3);
    reset = 1'b0;
    #1;
    chk("rst_mid_write", write_out, 1'b0);
    chk("rst_mid_data", data_out, 1'b0);
    chk("rst_mid_busy", busy_out, 1'b0);
    chk("rst_mid_status", status_out, 1'b0);
    sb.delete();
    data_in    = 8'h5A;
    enqueue_in = 1'b1;
    tick(); tick(); tick();
    enqueue_in = 1'b0;
    reset = 1'b1;
    hs = hi_cycles;
    for (int i = 0; i < 20; i++) tick();
    chk("rst_quiet_out", hi_cycles, hs);
    chk("rst_quiet_busy", busy_out, 1'b0);
    enq(8'h3C, 1'b1);
    wait_drain("rst_after", 40);

    // push on the pop edge, then three more: fills exactly at the 5th push
    starts.delete();
    enq(8'hA5, 1'b1);
    enq(8'h5A, 1'b1);
    chk("pp_status1", status_out, 1'b0);
    chk("pp_busy", busy_out, 1'b1);
    enq(8'h81, 1'b1);
    chk("pp_status2", status_out, 1'b0);
    enq(8'h7E, 1'b1);
    chk("pp_status3", status_out, 1'b0);
    enq(8'hC3, 1'b1);
    chk("pp_status4", status_out, 1'b1);
    wait_drain("pp", 200);
    chk("pp_nframes", starts.size(), 5);

    // parity-bearing frames (plain 8-bit frames without the macro)
    enq(8'h07, 1'b1);
    wait_drain("par07", 40);
    enq(8'h00, 1'b1);
    wait_drain("par00", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(60000 * 1000);
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
